// File: rtl/rsa_cmd_ctrl_if.sv
// ARM-facing command/data handshake bundle of the RSA accelerator.
// master = ARM side, slave = command sequencer.
interface rsa_cmd_ctrl_if;
    logic [31:0] arm_to_fpga_cmd;
    logic        arm_to_fpga_cmd_valid;
    logic        fpga_to_arm_done;
    logic        fpga_to_arm_done_read;
    logic        arm_to_fpga_data_valid;
    logic        arm_to_fpga_data_ready;
    logic        fpga_to_arm_data_valid;
    logic        fpga_to_arm_data_ready;

    // Handshakes: a word moves on a rising edge where its valid and ready are both 1;
    // done is held until done_read is seen on a later edge.
    modport master (
        output arm_to_fpga_cmd,
        output arm_to_fpga_cmd_valid,
        input  fpga_to_arm_done,
        output fpga_to_arm_done_read,
        output arm_to_fpga_data_valid,
        input  arm_to_fpga_data_ready,
        input  fpga_to_arm_data_valid,
        output fpga_to_arm_data_ready
    );

    modport slave (
        input  arm_to_fpga_cmd,
        input  arm_to_fpga_cmd_valid,
        output fpga_to_arm_done,
        input  fpga_to_arm_done_read,
        input  arm_to_fpga_data_valid,
        output arm_to_fpga_data_ready,
        output fpga_to_arm_data_valid,
        input  fpga_to_arm_data_ready
    );
endinterface

// File: rtl/rsa_cmd_ctrl.sv
// RSA accelerator command sequencer: decodes ARM commands, drives the ARM
// handshakes, datapath load strobes and start pulses, and counts compute cycles.
module rsa_cmd_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    rsa_cmd_ctrl_if.slave    arm,
    output logic             ld_mod,
    output logic             ld_rsq,
    output logic             ld_exp,
    output logic             start_mont,
    output logic             start_exp,
    input  logic             core_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [3:0]       leds
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_COMPUTE = 3'd2,
        S_TX      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] C_EXP      = 3'd0;
    localparam logic [2:0] C_MONT     = 3'd1;
    localparam logic [2:0] C_READ_MOD = 3'd2;
    localparam logic [2:0] C_READ_RSQ = 3'd3;
    localparam logic [2:0] C_READ_EXP = 3'd4;
    localparam logic [2:0] C_WRITE    = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] code;
    logic       err;

    logic       take_cmd;
    logic       cmd_legal;
    logic       cmd_compute;
    logic       first_cycle;

    assign take_cmd    = (state == S_IDLE) && arm.arm_to_fpga_cmd_valid;
    assign cmd_legal   = (arm.arm_to_fpga_cmd[31:3] == 29'd0) &&
                         (arm.arm_to_fpga_cmd[2:0] <= C_WRITE);
    assign cmd_compute = (arm.arm_to_fpga_cmd[2:0] == C_EXP) ||
                         (arm.arm_to_fpga_cmd[2:0] == C_MONT);
    // The start pulse flop is high exactly in the first COMPUTE cycle.
    assign first_cycle = start_exp | start_mont;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm.arm_to_fpga_cmd_valid) begin
                    if (!cmd_legal) begin
                        state_nxt = S_DONE;
                    end else if (cmd_compute) begin
                        state_nxt = S_COMPUTE;
                    end else if (arm.arm_to_fpga_cmd[2:0] == C_WRITE) begin
                        state_nxt = S_TX;
                    end else begin
                        state_nxt = S_RX;
                    end
                end
            end
            S_RX: begin
                if (arm.arm_to_fpga_data_valid) state_nxt = S_DONE;
            end
            S_COMPUTE: begin
                if (!first_cycle && core_done) state_nxt = S_DONE;
            end
            S_TX: begin
                if (arm.fpga_to_arm_data_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (arm.fpga_to_arm_done_read) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs plus the combinational load strobes
    always_comb begin
        arm.arm_to_fpga_data_ready = (state == S_RX);
        arm.fpga_to_arm_data_valid = (state == S_TX);
        arm.fpga_to_arm_done       = (state == S_DONE);
        leds                       = {err, state};
        ld_mod = (state == S_RX) && arm.arm_to_fpga_data_valid && (code == C_READ_MOD);
        ld_rsq = (state == S_RX) && arm.arm_to_fpga_data_valid && (code == C_READ_RSQ);
        ld_exp = (state == S_RX) && arm.arm_to_fpga_data_valid && (code == C_READ_EXP);
    end

    // Command latch, error flag, start pulses and compute-cycle counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            code        <= 3'd0;
            err         <= 1'b0;
            start_exp   <= 1'b0;
            start_mont  <= 1'b0;
            cycle_count <= '0;
        end else begin
            start_exp  <= take_cmd && cmd_legal && (arm.arm_to_fpga_cmd[2:0] == C_EXP);
            start_mont <= take_cmd && cmd_legal && (arm.arm_to_fpga_cmd[2:0] == C_MONT);
            if (take_cmd) begin
                if (cmd_legal) begin
                    code <= arm.arm_to_fpga_cmd[2:0];
                    err  <= 1'b0;
                end else begin
                    err  <= 1'b1;
                end
            end
            if (take_cmd && cmd_legal && cmd_compute) begin
                cycle_count <= '0;
            end else if ((state == S_COMPUTE) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Directed bench for rsa_cmd_ctrl: each command flow is driven by hand and
// every observed output is compared against a hand-computed value.
module tb_rsa_cmd_ctrl;

    logic        clk;
    logic        resetn;
    logic        ld_mod, ld_rsq, ld_exp;
    logic        start_mont, start_exp;
    logic        core_done;
    logic [31:0] cycle_count;
    logic [3:0]  leds;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    rsa_cmd_ctrl_if arm ();

    rsa_cmd_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .arm         (arm.slave),
        .ld_mod      (ld_mod),
        .ld_rsq      (ld_rsq),
        .ld_exp      (ld_exp),
        .start_mont  (start_mont),
        .start_exp   (start_exp),
        .core_done   (core_done),
        .cycle_count (cycle_count),
        .leds        (leds)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [31:0] c);
        arm.arm_to_fpga_cmd       = c;
        arm.arm_to_fpga_cmd_valid = 1'b1;
        tick(1);
        arm.arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic ack_done();
        arm.fpga_to_arm_done_read = 1'b1;
        tick(1);
        arm.fpga_to_arm_done_read = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_done"}, arm.fpga_to_arm_done, 0);
        check_eq({tag, "_dready"}, arm.arm_to_fpga_data_ready, 0);
        check_eq({tag, "_dvalid"}, arm.fpga_to_arm_data_valid, 0);
        check_eq({tag, "_ld"}, {ld_mod, ld_rsq, ld_exp}, 0);
        check_eq({tag, "_start"}, {start_mont, start_exp}, 0);
        check_eq({tag, "_count"}, cycle_count, 0);
        check_eq({tag, "_leds"}, leds, 4'h0);
    endtask

    initial begin
        resetn                     = 1'b0;
        core_done                  = 1'b0;
        arm.arm_to_fpga_cmd        = 32'd0;
        arm.arm_to_fpga_cmd_valid  = 1'b0;
        arm.fpga_to_arm_done_read  = 1'b0;
        arm.arm_to_fpga_data_valid = 1'b0;
        arm.fpga_to_arm_data_ready = 1'b0;

        // reset
        #25;
        check_all_zero("rst");
        #2 resetn = 1'b1;
        tick(2);
        check_eq("idle_after_rst", leds, 4'h0);

        // READ_MOD, data one cycle after the command
        do_cmd(32'd2);
        check_eq("rx_leds", leds, 4'h1);
        check_eq("rx_dready", arm.arm_to_fpga_data_ready, 1);
        check_eq("rx_ld_idle", {ld_mod, ld_rsq, ld_exp}, 3'b000);
        arm.arm_to_fpga_data_valid = 1'b1;
        #1;
        check_eq("rx_ld_mod", {ld_mod, ld_rsq, ld_exp}, 3'b100);
        tick(1);
        arm.arm_to_fpga_data_valid = 1'b0;
        check_eq("rmod_done", arm.fpga_to_arm_done, 1);
        check_eq("rmod_leds", leds, 4'h4);
        check_eq("rmod_ld_off", {ld_mod, ld_rsq, ld_exp}, 3'b000);
        ack_done();
        check_eq("rmod_idle", leds, 4'h0);

        // MONT, core_done in start cycle ignored, real core_done 40 cycles after start
        do_cmd(32'd1);
        check_eq("mont_start", {start_mont, start_exp}, 2'b10);
        check_eq("mont_leds", leds, 4'h2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        check_eq("mont_early_done_ignored", leds, 4'h2);
        pulses = 0;
        for (int i = 0; i < 39; i++) begin
            if (start_mont) pulses++;
            tick(1);
        end
        check_eq("mont_single_pulse", pulses, 0);
        check_eq("mont_still_compute", leds, 4'h2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        check_eq("mont_done", arm.fpga_to_arm_done, 1);
        check_eq("mont_count", cycle_count, 41);
        ack_done();

        // EXP with a stray cmd_valid during COMPUTE
        do_cmd(32'd0);
        check_eq("exp_start", {start_mont, start_exp}, 2'b01);
        tick(1);
        arm.arm_to_fpga_cmd       = 32'd5;
        arm.arm_to_fpga_cmd_valid = 1'b1;
        tick(1);
        arm.arm_to_fpga_cmd_valid = 1'b0;
        check_eq("exp_stray_cmd", leds, 4'h2);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        check_eq("exp_done_leds", leds, 4'h4);
        check_eq("exp_count", cycle_count, 3);
        ack_done();

        // WRITE with ready delayed 3 cycles
        do_cmd(32'd5);
        check_eq("tx_leds", leds, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check_eq("tx_valid_hold", arm.fpga_to_arm_data_valid, 1);
            tick(1);
        end
        check_eq("tx_valid_last", arm.fpga_to_arm_data_valid, 1);
        arm.fpga_to_arm_data_ready = 1'b1;
        tick(1);
        arm.fpga_to_arm_data_ready = 1'b0;
        check_eq("tx_done", arm.fpga_to_arm_done, 1);
        check_eq("tx_valid_off", arm.fpga_to_arm_data_valid, 0);
        ack_done();

        // illegal commands
        do_cmd(32'h7);
        check_eq("ill7_leds", leds, 4'hC);
        check_eq("ill7_strobes", {ld_mod, ld_rsq, ld_exp, start_mont, start_exp}, 0);
        ack_done();
        do_cmd(32'h8);
        check_eq("ill8_leds", leds, 4'hC);
        check_eq("ill8_strobes", {ld_mod, ld_rsq, ld_exp, start_mont, start_exp}, 0);
        ack_done();
        check_eq("ill_idle_err", leds, 4'h8);

        // READ_RSQ with data already valid clears err
        arm.arm_to_fpga_data_valid = 1'b1;
        do_cmd(32'd3);
        check_eq("rsq_leds", leds, 4'h1);
        check_eq("rsq_ld", {ld_mod, ld_rsq, ld_exp}, 3'b010);
        tick(1);
        arm.arm_to_fpga_data_valid = 1'b0;
        check_eq("rsq_done_leds", leds, 4'h4);
        ack_done();

        // done_read held high: done lasts exactly one cycle
        arm.fpga_to_arm_done_read = 1'b1;
        do_cmd(32'h6);
        check_eq("hold_done_hi", arm.fpga_to_arm_done, 1);
        tick(1);
        check_eq("hold_done_lo", arm.fpga_to_arm_done, 0);
        arm.fpga_to_arm_done_read = 1'b0;

        // async reset mid-COMPUTE
        do_cmd(32'd1);
        tick(3);
        check_eq("pre_rst_compute", leds, 4'h2);
        #2 resetn = 1'b0;
        #1;
        check_all_zero("rst_compute");
        #2 resetn = 1'b1;
        tick(1);

        // async reset mid-RX
        do_cmd(32'd4);
        check_eq("pre_rst_rx", arm.arm_to_fpga_data_ready, 1);
        #2 resetn = 1'b0;
        arm.arm_to_fpga_data_valid = 1'b1;
        #1;
        check_all_zero("rst_rx");
        arm.arm_to_fpga_data_valid = 1'b0;
        #2 resetn = 1'b1;
        tick(1);

        // MONT after reset
        do_cmd(32'd1);
        check_eq("post_rst_start", start_mont, 1);
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        check_eq("post_rst_done", arm.fpga_to_arm_done, 1);
        check_eq("post_rst_count", cycle_count, 2);
        ack_done();
        check_eq("post_rst_idle", leds, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_cmd_ctrl.md
# rsa_cmd_ctrl

Command sequencer for the RSA accelerator top level. It decodes 32-bit ARM commands and drives the ARM data-in and data-out handshakes. It issues load strobes for the modulus, R²/operand and exponent registers, starts the Montgomery-multiply or exponentiation datapath, and raises the done handshake. It sits between the ARM-facing ports of `rsa_wrapper` and the datapath, and owns no 1024-bit data itself.

## Interface
Parameters:
- `CNT_W`, default 32: width of the compute-cycle counter.

Ports. Reset is asynchronous and active-low (`resetn`). Everything is clocked on the rising edge of `clk`.
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous active-low reset
- `arm_to_fpga_cmd`  in  32  command word
- `arm_to_fpga_cmd_valid`  in  1  command strobe, sampled in IDLE only
- `fpga_to_arm_done`  out  1  command complete
- `fpga_to_arm_done_read`  in  1  ARM acknowledge of done
- `arm_to_fpga_data_valid`  in  1  ARM data word present
- `arm_to_fpga_data_ready`  out  1  controller accepts data
- `fpga_to_arm_data_valid`  out  1  result on bus is valid
- `fpga_to_arm_data_ready`  in  1  ARM ready to take result
- `ld_mod`, `ld_rsq`, `ld_exp`  out  1 each  datapath register capture enables
- `start_mont`, `start_exp`  out  1 each  one-cycle datapath start pulses
- `core_done`  in  1  datapath finished (level or pulse)
- `cycle_count`  out  CNT_W  cycles spent in the last or current COMPUTE
- `leds`  out  4  `{err, state[2:0]}`

## Operation
Command codes are taken from `cmd[2:0]`; `cmd[31:3]` must be zero, otherwise the command is illegal.
- 0: EXP
- 1: MONT
- 2: READ_MOD
- 3: READ_RSQ
- 4: READ_EXP
- 5: WRITE
- 6 and 7: illegal

States, with encoding: IDLE=0, RX=1, COMPUTE=2, TX=3, DONE=4.
- IDLE: when `cmd_valid` is high, latch the code.
  - Codes 2/3/4 go to RX.
  - Codes 0/1 go to COMPUTE.
  - Code 5 goes to TX.
  - An illegal code goes to DONE and sets `err`.
  - A legal command clears `err`.
- RX: `arm_to_fpga_data_ready`=1. In a cycle with `data_valid`=1:
  - Assert the `ld_*` matching the latched code, combinationally in that cycle (`ld_mod`, `ld_rsq` or `ld_exp` for codes 2, 3, 4).
  - Go to DONE.
- COMPUTE:
  - On the first cycle, `start_exp` (code 0) or `start_mont` (code 1) is high for exactly one cycle.
  - `core_done` is ignored in that first cycle.
  - From the second cycle on, `core_done`=1 moves the FSM to DONE.
  - `cycle_count` is cleared on entry, increments every COMPUTE cycle, and saturates at all-ones.
- TX: `fpga_to_arm_data_valid`=1. When `fpga_to_arm_data_ready`=1, go to DONE. The result bus is driven by the datapath, not by this block.
- DONE: `fpga_to_arm_done`=1 until `done_read`=1, then go to IDLE.
- `cmd_valid` outside IDLE is ignored: no latch, no error.
- Reset in any state, asynchronously:
  - State returns to IDLE.
  - `err`=0 and `cycle_count`=0.
  - All strobes, start pulses, ready/valid and done outputs drop to 0.
  - An in-flight datapath operation is abandoned. The datapath handles its own reset.

## Timing
- Outputs:
  - `data_ready`, `data_valid`, `done` and `leds` decode the registered state only (Moore).
  - `start_*` come from a flop.
  - `ld_*` are the only combinational outputs: `ld_x = (state==RX) & data_valid & (code==x)`.
- Latency, counted from the edge that samples `cmd_valid`:
  - RX is entered at the next edge.
  - With `data_valid` already high, `ld_*` fires in the first RX cycle and DONE follows one cycle later.
  - An illegal command reaches DONE one edge after sampling.
  - WRITE: TX is entered one edge after sampling, and DONE is reached one edge after `data_ready` is seen high.
- Simultaneous events:
  - `done_read` high on the same edge that DONE is entered is ignored; done stays high for at least one cycle.
  - `cmd_valid` in the DONE→IDLE cycle is not taken. IDLE must be visible for one cycle first.
- Holding `done_read` high continuously is allowed: each command then completes with done high for exactly one cycle.

## Test plan
- Reset with `resetn`=0 for 25 ns → every output 0, `leds`=4'h0. The FSM stays in IDLE after release.
- READ_MOD (cmd 2): data_valid asserted one cycle after the command → `ld_mod` high for one cycle, `ld_rsq`/`ld_exp` stay 0, done rises the next cycle, `leds`=4'h4. `done_read` returns `leds` to 4'h0.
- MONT (cmd 1), `core_done` pulsed 40 cycles after `start_mont` → `start_mont` is a single-cycle pulse, done follows, `cycle_count`=41. Also drive `core_done` high in the start cycle: it must be ignored.
- Run EXP (cmd 0) then WRITE (cmd 5) with `fpga_to_arm_data_ready` delayed 3 cycles → `fpga_to_arm_data_valid` holds high until ready, then done. A `cmd_valid` pulse during COMPUTE has no effect.
- Illegal command 32'h7, then 32'h8 → DONE with `leds`=4'hC in both cases, no `ld_*` or `start_*`. A following legal cmd 3 clears `err`.
- Deassert `resetn` mid-COMPUTE and mid-RX → asynchronous return to IDLE and all outputs 0. A new MONT after release completes normally.
